// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// Shift-add multiply and restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       op_q;
    logic [AW-1:0]    acc_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] a_orig_q;
    logic             div0_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_shift_c;
    logic             div_ge_c;
    logic [WIDTH-1:0] div_rem_c;
    logic [AW-1:0]    step_c;
    logic [AW-1:0]    prod_c;
    logic [WIDTH-1:0] quot_c;
    logic [WIDTH-1:0] rem_c;
    logic [WIDTH-1:0] res_hi_c;
    logic [WIDTH-1:0] res_lo_c;

    // Operand magnitudes; op[0] selects the signed variants.
    always_comb begin
        a_neg_c = op[0] & a[WIDTH-1];
        b_neg_c = op[0] & b[WIDTH-1];
        a_mag_c = a_neg_c ? (~a + WIDTH'(1)) : a;
        b_mag_c = b_neg_c ? (~b + WIDTH'(1)) : b;
    end

    // One iteration: multiply shifts the accumulator right, divide shifts the remainder:quotient left.
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
        div_shift_c = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
        div_ge_c    = div_shift_c >= {1'b0, opb_q};
        div_rem_c   = div_ge_c ? WIDTH'(div_shift_c - {1'b0, opb_q}) : div_shift_c[WIDTH-1:0];
        step_c      = op_q[1] ? {div_rem_c, acc_q[WIDTH-2:0], div_ge_c}
                              : {mul_sum_c, acc_q[WIDTH-1:1]};
    end

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        prod_c = neg_lo_q ? (~acc_q + AW'(1)) : acc_q;
        quot_c = neg_lo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem_c  = neg_hi_q ? (~acc_q[AW-1:WIDTH] + WIDTH'(1)) : acc_q[AW-1:WIDTH];
        if (!op_q[1]) begin
            res_hi_c = prod_c[AW-1:WIDTH];
            res_lo_c = prod_c[WIDTH-1:0];
        end else if (div0_q) begin
            res_hi_c = a_orig_q;
            res_lo_c = '1;
        end else begin
            res_hi_c = rem_c;
            res_lo_c = quot_c;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            a_orig_q <= '0;
            div0_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        acc_q    <= {WIDTH'(0), op[1] ? a_mag_c : b_mag_c};
                        opb_q    <= op[1] ? b_mag_c : a_mag_c;
                        a_orig_q <= a;
                        div0_q   <= (b == '0);
                        neg_lo_q <= a_neg_c ^ b_neg_c;
                        neg_hi_q <= a_neg_c;
                        cnt_q    <= CW'(WIDTH);
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                RUN: begin
                    acc_q <= step_c;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= res_hi_c;
                    lo_q    <= res_lo_c;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    mul_div_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ux;
        logic [63:0] uy;
        longint      sx;
        longint      sy;
        longint      q;
        longint      m;
        logic [63:0] r;
        ux = {32'h0, x};
        uy = {32'h0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: r = ux * uy;
            2'b01: r = 64'(sx * sy);
            2'b10: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[31:0], q[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int          cyc;
        logic [63:0] exp;
        exp = model(o, x, y);
        start_op(o, x, y);
        wait_done(cyc);
        chk("latency", 64'(cyc), 64'(33));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("result_hilo", {hi, lo}, exp);
    endtask

    initial begin
        int          cyc;
        int          seen;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] lo_before;
        logic [63:0] exp;

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_state", {30'h0, busy, done, hi, lo}, 64'h0);

        // Directed arithmetic cases
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_ff", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        tick();
        chk("done_one_cycle", 64'(done), 64'(0));
        do_op(2'b01, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg3x7", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        chk("multu_fffdx7", {hi, lo}, {32'h0000_0006, 32'hFFFF_FFEB});
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(2'b10, 32'd100, 32'd0);
        chk("divu_by0", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
        do_op(2'b11, 32'hFFFF_FFF9, 32'd0);
        chk("div_by0_neg", {hi, lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_overflow", {hi, lo}, {32'h0, 32'h8000_0000});
        tick();

        // MTHI / MTLO writes in IDLE
        hi_we = 1'b1; wdata = 32'h1234;
        tick();
        hi_we = 1'b0;
        chk("mthi", 64'(hi), 64'(32'h1234));
        lo_we = 1'b1; wdata = 32'hCAFE;
        tick();
        lo_we = 1'b0;
        chk("mtlo", {hi, lo}, {32'h1234, 32'hCAFE});

        // Start and write strobes during RUN are ignored
        x = $urandom; y = $urandom;
        exp = model(2'b00, x, y);
        lo_before = lo;
        start_op(2'b00, x, y);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; op = 2'b10; lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h0BAD;
            tick();
            start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
            chk("hi_held_in_run", 64'(hi), 64'(32'h1234));
            chk("lo_held_in_run", 64'(lo), 64'(lo_before));
        end
        wait_done(cyc);
        chk("latency_with_noise", 64'(cyc + 5), 64'(33));
        chk("result_ignores_noise", {hi, lo}, exp);
        tick();
        chk("start_not_queued", 64'(busy), 64'(0));

        // Start wins over a same-cycle MTHI
        hi_we = 1'b1; wdata = 32'hDEAD;
        x = hi;
        start_op(2'b00, 32'd2, 32'd3);
        hi_we = 1'b0;
        chk("start_beats_mthi", 64'(hi), 64'(x));
        wait_done(cyc);
        chk("start_beats_mthi_res", {hi, lo}, {32'h0, 32'd6});

        // Back-to-back: second start driven on the done cycle
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000);
        do_op(2'b10, 32'd1000, 32'd7);
        chk("b2b_divu", {hi, lo}, {32'd6, 32'd142});

        // Reset during RUN aborts and clears hi/lo
        tick();
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi_mtlo_both", {hi, lo}, {32'h55, 32'h55});
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_state", {30'h0, busy, done, hi, lo}, 64'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'(0));

        // Random operations against the model
        for (int i = 0; i < 16; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'h0;
                1: y = $urandom_range(1, 15);
                2: y = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: y = $urandom;
            endcase
            do_op(2'($urandom_range(0, 3)), x, y);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
